// File: rtl/tmds_video_timing_if.sv
// Bus between the raster timing / test-pattern source and its consumer.
//
// Purpose: bundles the pixel-rate enable, pattern controls and the aligned
// timing/pixel outputs.
//
// Ports (interface members):
//   en          pixel-rate enable (master -> slave)
//   pattern_sel 00 bars, 01 checkerboard, 10 gradient, 11 solid (master -> slave)
//   solid_rgb   {R,G,B} for the solid pattern (master -> slave)
//   de, hsync, vsync, x, y, frame_start, line_start, r, g, b
//               registered timing and pixel outputs (slave -> master)
interface tmds_video_timing_if #(
  parameter int CW = 12
);
  logic          en;
  logic [1:0]    pattern_sel;
  logic [23:0]   solid_rgb;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          frame_start;
  logic          line_start;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;

  modport master (
    output en, pattern_sel, solid_rgb,
    input  de, hsync, vsync, x, y, frame_start, line_start, r, g, b
  );

  modport slave (
    input  en, pattern_sel, solid_rgb,
    output de, hsync, vsync, x, y, frame_start, line_start, r, g, b
  );
endinterface

// File: rtl/tmds_video_timing.sv
// Raster timing generator and RGB test-pattern source for three TMDS encoders.
//
// Purpose: walks an (h,v) raster and produces DE, HSYNC/VSYNC, active-region
// coordinates, frame/line start pulses and an 8-bit-per-channel test pattern.
// Every output is registered from the pre-increment (h,v), so all of them are
// aligned with one enabled cycle of latency.
//
// Ports:
//   clk  pixel clock
//   rst  synchronous active-high reset
//   vif  tmds_video_timing_if.slave: en, pattern_sel, solid_rgb in;
//        de, hsync, vsync, x, y, frame_start, line_start, r, g, b out
module tmds_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  tmds_video_timing_if.slave     vif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_MAX_C    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] HS_BEG_C   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_MAX_C    = CW'(V_TOT - 1);
  localparam logic [CW-1:0] VS_BEG_C   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_LAST_C = CW'(BAR_W - 1);

  // Raster position and pattern state
  logic [CW-1:0] h_r;
  logic [CW-1:0] v_r;
  logic [1:0]    pat_r;
  logic [CW-1:0] bar_pos_r;
  logic [2:0]    bar_idx_r;

  // Output registers
  logic          de_r;
  logic          hsync_r;
  logic          vsync_r;
  logic [CW-1:0] x_r;
  logic [CW-1:0] y_r;
  logic          frame_start_r;
  logic          line_start_r;
  logic [7:0]    r_r;
  logic [7:0]    g_r;
  logic [7:0]    b_r;

  // Combinational next-output values derived from the current (h,v)
  logic          at_origin_s;
  logic [1:0]    pat_s;
  logic          de_s;
  logic          hsync_s;
  logic          vsync_s;
  logic [7:0]    grad_b_s;
  logic [23:0]   rgb_s;

  // Decode timing and select the pixel colour for the current raster position
  always_comb begin
    at_origin_s = (h_r == ZERO_C) && (v_r == ZERO_C);
    // The pattern sampled at (0,0) already applies to pixel (0,0) itself.
    pat_s    = at_origin_s ? vif.pattern_sel : pat_r;
    de_s     = (h_r < H_ACT_C) && (v_r < V_ACT_C);
    hsync_s  = ((h_r >= HS_BEG_C) && (h_r < HS_END_C)) ? HS_POL : ~HS_POL;
    // v only changes on the h wrap, so vsync naturally switches with h==0.
    vsync_s  = ((v_r >= VS_BEG_C) && (v_r < VS_END_C)) ? VS_POL : ~VS_POL;
    grad_b_s = h_r[7:0] + v_r[7:0];
    rgb_s    = 24'h000000;
    if (de_s) begin
      case (pat_s)
        2'b00: begin
          case (bar_idx_r)
            3'd0:    rgb_s = 24'hFFFFFF;
            3'd1:    rgb_s = 24'hFFFF00;
            3'd2:    rgb_s = 24'h00FFFF;
            3'd3:    rgb_s = 24'h00FF00;
            3'd4:    rgb_s = 24'hFF00FF;
            3'd5:    rgb_s = 24'hFF0000;
            3'd6:    rgb_s = 24'h0000FF;
            default: rgb_s = 24'h000000;
          endcase
        end
        2'b01:   rgb_s = (h_r[5] ^ v_r[5]) ? 24'hFFFFFF : 24'h000000;
        2'b10:   rgb_s = {h_r[7:0], v_r[7:0], grad_b_s};
        2'b11:   rgb_s = vif.solid_rgb;
        default: rgb_s = 24'h000000;
      endcase
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Advance the h/v raster counters on every enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r <= ZERO_C;
      v_r <= ZERO_C;
    end else if (vif.en) begin
      if (h_r == H_MAX_C) begin
        h_r <= ZERO_C;
        v_r <= (v_r == V_MAX_C) ? ZERO_C : (v_r + ONE_C);
      end else begin
        h_r <= h_r + ONE_C;
      end
    end
  end

  // Track the colour-bar index with a per-bar pixel counter instead of dividing h
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_pos_r <= ZERO_C;
      bar_idx_r <= 3'd0;
    end else if (vif.en) begin
      if (h_r == H_MAX_C) begin
        bar_pos_r <= ZERO_C;
        bar_idx_r <= 3'd0;
      end else if (bar_pos_r == BAR_LAST_C) begin
        bar_pos_r <= ZERO_C;
        bar_idx_r <= bar_idx_r + 3'd1;
      end else begin
        bar_pos_r <= bar_pos_r + ONE_C;
      end
    end
  end

  // Latch the pattern selection once per frame at the raster origin
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= 2'b00;
    end else if (vif.en && at_origin_s) begin
      pat_r <= vif.pattern_sel;
    end
  end

  // Register every output together so timing and pixel stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      de_r          <= 1'b0;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      x_r           <= ZERO_C;
      y_r           <= ZERO_C;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
      r_r           <= 8'h00;
      g_r           <= 8'h00;
      b_r           <= 8'h00;
    end else if (vif.en) begin
      de_r          <= de_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      x_r           <= de_s ? h_r : ZERO_C;
      y_r           <= de_s ? v_r : ZERO_C;
      frame_start_r <= at_origin_s;
      line_start_r  <= (h_r == ZERO_C);
      r_r           <= rgb_s[23:16];
      g_r           <= rgb_s[15:8];
      b_r           <= rgb_s[7:0];
    end
  end

  assign vif.de          = de_r;
  assign vif.hsync       = hsync_r;
  assign vif.vsync       = vsync_r;
  assign vif.x           = x_r;
  assign vif.y           = y_r;
  assign vif.frame_start = frame_start_r;
  assign vif.line_start  = line_start_r;
  assign vif.r           = r_r;
  assign vif.g           = g_r;
  assign vif.b           = b_r;

endmodule

// File: tb/tb_tmds_video_timing.sv
// Self-checking bench for tmds_video_timing on a 16x8 raster.
// A behavioural model pushes the expected output set for each clock edge into
// a queue; after the edge the entry is popped and compared with the DUT.
// Directed checks with fixed expected values cover the raster landmarks.
module tb_tmds_video_timing;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int CW       = 12;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fs;
    logic          ls;
    logic [23:0]   rgb;
  } out_t;

  logic clk;
  logic rst;

  tmds_video_timing_if #(.CW(CW)) vif ();

  tmds_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   k      = 0;
  int   mh     = 0;
  int   mv     = 0;
  int   de_cnt = 0;
  logic [1:0] mpat = 2'b00;
  out_t last_e;
  out_t exp_q[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, expv);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int hh, input int vv,
                                            input logic [1:0] p, input logic [23:0] s);
    logic [23:0] c;
    case (p)
      2'b00:   c = bars[hh / (H_ACTIVE / 8)];
      2'b01:   c = ((((hh >> 5) ^ (vv >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2'b10:   c = {8'(hh), 8'(vv), 8'(hh + vv)};
      default: c = s;
    endcase
    return c;
  endfunction

  // One clock edge: model the expected outputs, push, then pop and compare.
  task automatic tick();
    out_t e;
    out_t o;
    logic [1:0] p;
    if (rst) begin
      e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, x: '0, y: '0, fs: 1'b0, ls: 1'b0, rgb: 24'h0};
      mh = 0; mv = 0; mpat = 2'b00; k = 0;
    end else if (vif.en) begin
      k++;
      p = (mh == 0 && mv == 0) ? vif.pattern_sel : mpat;
      if (mh == 0 && mv == 0) mpat = vif.pattern_sel;
      e.de  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
      e.hs  = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
      e.vs  = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
      e.x   = e.de ? CW'(mh) : '0;
      e.y   = e.de ? CW'(mv) : '0;
      e.fs  = (mh == 0) && (mv == 0);
      e.ls  = (mh == 0);
      e.rgb = e.de ? model_rgb(mh, mv, p, vif.solid_rgb) : 24'h0;
      mh++;
      if (mh == H_TOT) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end
    end else begin
      e = last_e;
    end
    last_e = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = '{de: vif.de, hs: vif.hsync, vs: vif.vsync, x: vif.x, y: vif.y,
          fs: vif.frame_start, ls: vif.line_start, rgb: {vif.r, vif.g, vif.b}};
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL scoreboard edge=%0d observed=%h expected=%h", k, o, e);
    end
  endtask

  initial begin
    int f;
    rst             = 1'b1;
    vif.en          = 1'b1;
    vif.pattern_sel = 2'b00;
    vif.solid_rgb   = 24'h000000;
    last_e          = '0;

    // Reset held for three cycles: outputs at reset values.
    for (int i = 0; i < 3; i++) tick();
    chk("rst_de", 32'(vif.de), 32'd0);
    chk("rst_hsync", 32'(vif.hsync), 32'd1);
    chk("rst_vsync", 32'(vif.vsync), 32'd1);
    chk("rst_rgb", 32'({vif.r, vif.g, vif.b}), 32'h0);
    rst = 1'b0;

    // Two full frames with landmarks checked against fixed values.
    for (int e = 1; e <= 256; e++) begin
      if (e == 40) begin
        vif.pattern_sel = 2'b11;
        vif.solid_rgb   = 24'h123456;
      end
      if (e == 200) vif.pattern_sel = 2'b10;
      tick();
      f = (e - 1) % 128;
      de_cnt += 32'(vif.de);
      chk("line_start", 32'(vif.line_start), 32'(((e - 1) % 16) == 0));
      chk("frame_start", 32'(vif.frame_start), 32'(f == 0));
      chk("vsync", 32'(vif.vsync), 32'(!(f >= 80 && f < 112)));
      if (e <= 16) begin
        chk("hsync", 32'(vif.hsync), 32'(!(e >= 11 && e <= 13)));
        chk("de_line0", 32'(vif.de), 32'(e <= 8));
        if (e <= 8) chk("bars_line0", 32'({vif.r, vif.g, vif.b}), 32'(bars[e - 1]));
        else        chk("blank_rgb", 32'({vif.r, vif.g, vif.b}), 32'h0);
      end
      if (e == 1) begin
        chk("e1_x", 32'(vif.x), 32'd0);
        chk("e1_y", 32'(vif.y), 32'd0);
      end
      if (e == 17) chk("e17_y", 32'(vif.y), 32'd1);
      if (e >= 49 && e <= 56) chk("bars_hold", 32'({vif.r, vif.g, vif.b}), 32'(bars[e - 49]));
      if (e >= 129 && ((e - 1) % 16) < 8 && (f / 16) < 4)
        chk("solid_rgb", 32'({vif.r, vif.g, vif.b}), 32'h123456);
      if (e == 128 || e == 256) begin
        chk("de_per_frame", 32'(de_cnt), 32'd32);
        de_cnt = 0;
      end
    end

    // Five gradient pixels, then freeze mid-line with en low.
    for (int i = 0; i < 5; i++) tick();
    chk("grad_x4", 32'({vif.r, vif.g, vif.b}), 32'h040004);
    vif.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frozen_x", 32'(vif.x), 32'd4);
      chk("frozen_de", 32'(vif.de), 32'd1);
      chk("frozen_ls", 32'(vif.line_start), 32'd0);
    end

    // Reset with en low still takes effect.
    vif.pattern_sel = 2'b00;
    rst = 1'b1;
    tick();
    chk("rst2_de", 32'(vif.de), 32'd0);
    chk("rst2_x", 32'(vif.x), 32'd0);
    chk("rst2_hsync", 32'(vif.hsync), 32'd1);
    rst = 1'b0;
    vif.en = 1'b1;
    tick();
    chk("re_de", 32'(vif.de), 32'd1);
    chk("re_x", 32'(vif.x), 32'd0);
    chk("re_y", 32'(vif.y), 32'd0);
    chk("re_fs", 32'(vif.frame_start), 32'd1);
    chk("re_ls", 32'(vif.line_start), 32'd1);
    chk("re_rgb", 32'({vif.r, vif.g, vif.b}), 32'hFFFFFF);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
